// File: rtl/lpc_reg_arbiter.sv
// Arbiter that shares the LPC register bank write/read port between host
// writes (absolute priority) and two internal requesters (round-robin).
module lpc_reg_arbiter #(
  parameter logic [7:0]  WD_ADDR = 8'h01,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             LpcClock,
  input  logic             PciReset,
  input  logic             Wr,
  input  logic [7:0]       AddrReg,
  input  logic [7:0]       DataWr,
  input  logic             ReqA,
  input  logic             ReqB,
  input  logic             ReqWrA,
  input  logic             ReqWrB,
  input  logic [7:0]       ReqAddrA,
  input  logic [7:0]       ReqAddrB,
  input  logic [7:0]       ReqDataA,
  input  logic [7:0]       ReqDataB,
  input  logic [7:0]       RegRdData,
  output logic             RegWr,
  output logic [7:0]       RegAddr,
  output logic [7:0]       RegData,
  output logic             GntA,
  output logic             GntB,
  output logic             GntErr,
  output logic [7:0]       RdData,
  output logic             Busy,
  output logic [CNT_W-1:0] CollisionCnt
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;

  state_t           state, state_d;
  logic             sel_b, sel_b_d;
  logic             last_b, last_b_d;
  logic             lat_wr, lat_wr_d;
  logic [AW-1:0]    lat_addr, lat_addr_d;
  logic [DW-1:0]    lat_data, lat_data_d;
  logic             reg_wr_d;
  logic [AW-1:0]    reg_addr_d;
  logic [DW-1:0]    reg_data_d;
  logic [DW-1:0]    rd_data_d;
  logic             gnt_a_d, gnt_b_d, gnt_err_d;
  logic             busy_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             pick_b;

  // Round-robin pick: with both requesting, serve the one not served last
  assign pick_b = (ReqA && ReqB) ? !last_b : ReqB;

  // Saturating collision increment
  assign cnt_inc = (CollisionCnt == {CNT_W{1'b1}}) ? CollisionCnt
                                                   : CollisionCnt + CNT_W'(1);

  // State register and all registered outputs
  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      state        <= IDLE;
      sel_b        <= 1'b0;
      last_b       <= 1'b1;
      lat_wr       <= 1'b0;
      lat_addr     <= '0;
      lat_data     <= '0;
      RegWr        <= 1'b0;
      RegAddr      <= '0;
      RegData      <= '0;
      RdData       <= '0;
      GntA         <= 1'b0;
      GntB         <= 1'b0;
      GntErr       <= 1'b0;
      Busy         <= 1'b0;
      CollisionCnt <= '0;
    end else begin
      state        <= state_d;
      sel_b        <= sel_b_d;
      last_b       <= last_b_d;
      lat_wr       <= lat_wr_d;
      lat_addr     <= lat_addr_d;
      lat_data     <= lat_data_d;
      RegWr        <= reg_wr_d;
      RegAddr      <= reg_addr_d;
      RegData      <= reg_data_d;
      RdData       <= rd_data_d;
      GntA         <= gnt_a_d;
      GntB         <= gnt_b_d;
      GntErr       <= gnt_err_d;
      Busy         <= busy_d;
      CollisionCnt <= cnt_d;
    end
  end

  // Next-state and next-output logic; host write always wins the port
  always_comb begin
    state_d    = state;
    sel_b_d    = sel_b;
    last_b_d   = last_b;
    lat_wr_d   = lat_wr;
    lat_addr_d = lat_addr;
    lat_data_d = lat_data;
    reg_wr_d   = 1'b0;
    reg_addr_d = RegAddr;
    reg_data_d = RegData;
    rd_data_d  = RdData;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    gnt_err_d  = 1'b0;
    cnt_d      = CollisionCnt;

    if (Wr) begin
      reg_wr_d   = 1'b1;
      reg_addr_d = AddrReg;
      reg_data_d = DataWr;
    end

    case (state)
      IDLE: begin
        if (!Wr && (ReqA || ReqB)) begin
          sel_b_d    = pick_b;
          lat_wr_d   = pick_b ? ReqWrB   : ReqWrA;
          lat_addr_d = pick_b ? ReqAddrB : ReqAddrA;
          lat_data_d = pick_b ? ReqDataB : ReqDataA;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (Wr) begin
          cnt_d = cnt_inc;
        end else if (lat_wr) begin
          if (lat_addr == WD_ADDR) begin
            gnt_err_d = 1'b1;
          end else begin
            reg_wr_d   = 1'b1;
            reg_addr_d = lat_addr;
            reg_data_d = lat_data;
          end
          gnt_a_d = !sel_b;
          gnt_b_d = sel_b;
          state_d = ACK;
        end else begin
          reg_addr_d = lat_addr;
          state_d    = RDWAIT;
        end
      end
      RDWAIT: begin
        // A host write clobbers RegAddr, so the read must be reissued
        if (Wr) begin
          cnt_d   = cnt_inc;
          state_d = ISSUE;
        end else begin
          rd_data_d = RegRdData;
          gnt_a_d   = !sel_b;
          gnt_b_d   = sel_b;
          state_d   = ACK;
        end
      end
      ACK: begin
        last_b_d = sel_b;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: doc/lpc_reg_arbiter.md
LPC_REG_ARBITER -- requirements
Module: lpc_reg_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter WD_ADDR, default 8'h01, naming the register address that internal requesters may not write.
REQ-002 The block SHALL have parameter CNT_W, default 8, setting the width of the collision counter.

Ports:
REQ-003 The block SHALL have port LpcClock, input, 1 bit: the single 33 MHz clock for all flops.
REQ-004 The block SHALL have port PciReset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports Wr / AddrReg / DataWr, inputs, 1 / 8 / 8 bits: host write strobe (1-cycle pulse), host address and host data from the LPC decoder.
REQ-006 The block SHALL have ports ReqA / ReqB, inputs, 1 bit each: internal request, held high until the matching grant.
REQ-007 The block SHALL have ports ReqWrA / ReqWrB, inputs, 1 bit each: request type, 1 = write, 0 = read.
REQ-008 The block SHALL have ports ReqAddrA / ReqAddrB / ReqDataA / ReqDataB, inputs, 8 bits each: request address and write data.
REQ-009 The block SHALL have port RegRdData, input, 8 bits: combinational read data from the register mux, indexed by RegAddr.
REQ-010 The block SHALL have ports RegWr / RegAddr / RegData, outputs, 1 / 8 / 8 bits: registered write port to the register bank.
REQ-011 The block SHALL have ports GntA / GntB / GntErr, outputs, 1 bit each: completion pulse per requester; GntErr is valid only while a grant is high.
REQ-012 The block SHALL have ports RdData (output, 8 bits: captured read data, valid with the grant), Busy (output, 1 bit: state != IDLE) and CollisionCnt (output, CNT_W bits: host pre-emption count).

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, RDWAIT and ACK.
REQ-014 Host priority SHALL be absolute.
- Any cycle with Wr=1, in any state: next cycle RegWr=1, RegAddr=AddrReg, RegData=DataWr.
- Host writes SHALL never be stalled or dropped.
REQ-015 RegWr SHALL be a 1-cycle pulse; RegAddr and RegData SHALL hold their last value when not updated.
REQ-016 In IDLE with Wr=0 and at least one Req high, the block SHALL select a requester, latch its type/address/data and go to ISSUE.
- With Wr=1, IDLE SHALL stay IDLE.
REQ-017 Selection SHALL be round-robin.
- With both Reqs high, grant the requester not last served.
- After reset, A SHALL be favoured.
- The last-served pointer SHALL update only on ACK.
REQ-018 ISSUE with Wr=1 SHALL stay in ISSUE and retry next cycle.
REQ-019 ISSUE with Wr=0 SHALL act on the latched request:
- Write to WD_ADDR: no RegWr, GntErr<=1, go to ACK.
- Other write: RegWr<=1, RegAddr/RegData<=latched values, go to ACK.
- Read: RegAddr<=latched address, go to RDWAIT.
REQ-020 RDWAIT with Wr=0 SHALL set RdData<=RegRdData and go to ACK.
REQ-021 RDWAIT with Wr=1 SHALL go back to ISSUE, because the host write overwrites RegAddr and the read is retried.
REQ-022 Grant outputs SHALL be registered and high exactly during the ACK cycle, with GntA or GntB matching the selection.
- ACK SHALL always go to IDLE next.
- A host write during ACK is serviced and does not affect the grant.
REQ-023 Latency with no host traffic SHALL be:
- Write: RegWr and grant 2 cycles after Req is first sampled in IDLE.
- Read: grant and RdData 3 cycles after Req is first sampled in IDLE.
REQ-024 Each host Wr seen in ISSUE or RDWAIT SHALL increment CollisionCnt by 1, saturating at all-ones with no wrap.
REQ-025 A requester SHALL drop its Req in the cycle after its grant.
- Req deasserted before its grant (abandon) SHALL be ignored once latched; the operation completes and the grant still pulses.

Reset
REQ-026 PciReset=1 at a clock edge SHALL set the following, with no grant issued for an aborted operation:
- State = IDLE.
- RegWr, GntA, GntB, GntErr = 0.
- RegAddr, RegData, RdData = 0.
- CollisionCnt = 0; the pointer favours A.
REQ-027 Reset asserted mid-operation (ISSUE, RDWAIT or ACK) SHALL abort without any RegWr or grant in the following cycle.

Verification
REQ-028 Internal write: ReqA=1, ReqWrA=1, Addr 8'h05, Data 8'h3C, no host traffic -> 2 cycles later RegWr=1, RegAddr=05, RegData=3C and GntA=1 in the same cycle, GntErr=0.
REQ-029 Internal read: ReqB=1 read, Addr 8'h10, RegRdData=8'hA5 -> GntB=1 and RdData=A5 on cycle 3, RegWr never high.
REQ-030 Contention: ReqA and ReqB high continuously from reset -> grant order A, B, A, B; no grant ever overlaps another.
REQ-031 Host pre-emption: host Wr (Addr 8'h02, Data 8'h77) in the ISSUE cycle of an internal write -> RegWr carries 02/77 first, the internal write follows 1 cycle later, CollisionCnt=1.
REQ-032 Protected write and saturation:
- Internal write to 8'h01 -> GntErr=1 with grant, no RegWr.
- With CNT_W=2 and 5 collisions -> CollisionCnt=3.
REQ-033 Reset in RDWAIT -> next cycle all outputs 0 and state IDLE, no grant; a new request then completes normally.
